// File: rtl/div_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_arbiter_pkg                                                       |
// | State encoding and shared constants for the divider arbiter.          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package div_arbiter_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam int         c_timeout_default = 20;
    localparam logic [7:0] c_sat             = 8'hFF;

    // Counter must hold TIMEOUT itself and never be narrower than 5 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 5) ? w : 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_arbiter_rr_pick2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick2                                                              |
// | Two-way round-robin picker; ties go to the requester not last served. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_pick2
    import div_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        gnt   = 1'b0;
        if (req0 && req1) begin
            gnt = ~last_gnt;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_arbiter                                                           |
// | Shares one external divider between two requesters, with zero-divisor |
// | bypass and a sticky timeout abort.                                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] q_out,
    output logic [7:0] r_out,
    output logic       err,
    output logic       busy,
    output logic       load,
    output logic [7:0] d1,
    output logic [7:0] d2,
    input  logic       ready,
    input  logic [7:0] QUOTN,
    input  logic [7:0] REMDR
);

    localparam int c_cnt_w = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic               r_gnt, w_gnt_nxt;
    logic               r_last_gnt, w_last_gnt_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_load, w_load_nxt;
    logic               r_done0, w_done0_nxt;
    logic               r_done1, w_done1_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_err, w_err_nxt;
    logic [7:0]         r_d1, w_d1_nxt;
    logic [7:0]         r_d2, w_d2_nxt;
    logic [7:0]         r_q, w_q_nxt;
    logic [7:0]         r_r, w_r_nxt;

    logic               w_pick_gnt;
    logic               w_pick_valid;
    logic [7:0]         w_sel_a;
    logic [7:0]         w_sel_b;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (r_last_gnt),
        .gnt      (w_pick_gnt),
        .valid    (w_pick_valid)
    );

    assign w_sel_a = w_pick_gnt ? a1 : a0;
    assign w_sel_b = w_pick_gnt ? b1 : b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
            r_load     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_d1       <= 8'h00;
            r_d2       <= 8'h00;
            r_q        <= 8'h00;
            r_r        <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_load     <= w_load_nxt;
            r_done0    <= w_done0_nxt;
            r_done1    <= w_done1_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            r_d1       <= w_d1_nxt;
            r_d2       <= w_d2_nxt;
            r_q        <= w_q_nxt;
            r_r        <= w_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_gnt_nxt = r_last_gnt;
        w_cnt_nxt      = r_cnt;
        w_load_nxt     = 1'b0;
        w_done0_nxt    = 1'b0;
        w_done1_nxt    = 1'b0;
        w_err_nxt      = r_err;
        w_d1_nxt       = r_d1;
        w_d2_nxt       = r_d2;
        w_q_nxt        = r_q;
        w_r_nxt        = r_r;

        case (r_state)
            c_st_idle: begin
                if (w_pick_valid) begin
                    w_gnt_nxt = w_pick_gnt;
                    if (w_sel_b != 8'h00) begin
                        w_d1_nxt    = w_sel_a;
                        w_d2_nxt    = w_sel_b;
                        w_load_nxt  = 1'b1;
                        w_state_nxt = c_st_load;
                    end else begin
                        // Divide by zero never touches the shared divider.
                        w_q_nxt     = c_sat;
                        w_r_nxt     = w_sel_a;
                        w_state_nxt = c_st_resp;
                    end
                end
            end
            c_st_load: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (ready) begin
                    w_q_nxt     = QUOTN;
                    w_r_nxt     = REMDR;
                    w_state_nxt = c_st_resp;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_last) begin
                        w_err_nxt   = 1'b1;
                        w_q_nxt     = c_sat;
                        w_r_nxt     = c_sat;
                        w_state_nxt = c_st_resp;
                    end
                end
            end
            c_st_resp: begin
                w_last_gnt_nxt = r_gnt;
                w_state_nxt    = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        // Done is raised on the way into RESP so it is visible during RESP.
        if ((w_state_nxt == c_st_resp) && (r_state != c_st_resp)) begin
            w_done0_nxt = ~w_gnt_nxt;
            w_done1_nxt = w_gnt_nxt;
        end

        w_busy_nxt = (w_state_nxt != c_st_idle);
    end

    assign done0 = r_done0;
    assign done1 = r_done1;
    assign q_out = r_q;
    assign r_out = r_r;
    assign err   = r_err;
    assign busy  = r_busy;
    assign load  = r_load;
    assign d1    = r_d1;
    assign d2    = r_d2;

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20, giving the maximum WAIT cycles before abort.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: requester k asks for a division and holds the request until its done pulse.
REQ-005 SHALL have ports a0, b0, a1 and b1, input, 8 bits each: dividend and divisor of requester k, stable while reqk is high.
REQ-006 SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse saying the result for requester k is valid.
REQ-007 SHALL have ports q_out and r_out, output, 8 bits each: quotient and remainder, valid while donek is high.
REQ-008 SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port load, output, 1 bit: one-cycle start pulse to the shared divider.
REQ-011 SHALL have ports d1 and d2, output, 8 bits each: divider dividend and divisor, held from LOAD through WAIT.
REQ-012 SHALL have port ready, input, 1 bit: divider result valid.
REQ-013 SHALL have ports QUOTN and REMDR, input, 8 bits each: divider quotient and remainder.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, WAIT, RESP; all outputs SHALL be registered.
REQ-015 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-016 In IDLE with one request, that requester SHALL be granted.
REQ-017 In IDLE with both requests, the requester other than last_gnt SHALL be granted (round-robin); last_gnt SHALL reset to 1, so requester 0 wins the first tie.
REQ-018 On grant with divisor != 0, the FSM SHALL latch the operands into d1/d2 and go to LOAD.
REQ-019 On grant with divisor == 0, the FSM SHALL bypass the divider: q_out=8'hFF, r_out=dividend, go directly to RESP, with no load pulse.
REQ-020 LOAD SHALL assert load for exactly one cycle, clear the wait counter, and go to WAIT; ready sampled during LOAD SHALL be ignored.
REQ-021 In WAIT with ready=1, the FSM SHALL capture QUOTN/REMDR into q_out/r_out and go to RESP.
REQ-022 In WAIT with ready=0, the wait counter SHALL increment; when it reaches TIMEOUT, the FSM SHALL set err, force q_out=r_out=8'hFF, and go to RESP.
REQ-023 RESP SHALL pulse done of the granted requester for one cycle, update last_gnt, and return to IDLE.
REQ-024 A request seen in RESP SHALL NOT be granted until the following IDLE cycle.
REQ-025 Latency SHALL be: reqk sampled in IDLE at cycle t gives load at t+1; ready at cycle w in WAIT gives donek at w+1; a zero divisor gives donek at t+1.
REQ-026 The wait counter SHALL be 5 bits wide minimum (holds TIMEOUT) and SHALL NOT wrap within one transaction.
REQ-027 A requester dropping req mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-028 err SHALL remain set until rst.

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL go to IDLE.
REQ-030 On rst=1, load, done0, done1, busy and err SHALL be 0.
REQ-031 On rst=1, d1, d2, q_out and r_out SHALL be 8'h00, the counter SHALL be 0, and last_gnt SHALL be 1.
REQ-032 Reset asserted mid-transaction SHALL discard that transaction with no done pulse; a later ready from the divider SHALL be ignored in IDLE.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=0, LOAD=1, WAIT=2, RESP=3), the default TIMEOUT, and the 8'hFF saturation constant.
REQ-034 The round-robin picker SHALL be one sub-module, rr_pick2 (inputs req0, req1, last_gnt; output the granted index and a valid flag).
REQ-035 The divider SHALL stay external to div_arbiter.

Verification
REQ-036 Single request: req0, a0=200, b0=7, divider model ready after 8 cycles -> one load pulse, done0 with q_out=28, r_out=4; done1 stays 0.
REQ-037 Simultaneous requests: req0 (100,9) and req1 (50,6) both high after reset -> requester 0 served first (11,1), then requester 1 (8,2).
REQ-038 Zero divisor: req1, a1=77, b1=0 -> no load pulse; done1 one cycle after grant with q_out=255, r_out=77; err stays 0.
REQ-039 Timeout: model never asserts ready -> done pulse after TIMEOUT WAIT cycles with q_out=r_out=255; err=1 and remains 1 until rst.
REQ-040 Reset in WAIT: rst asserted at WAIT cycle 3 -> IDLE next cycle, all outputs at reset values, no done pulse; a later ready is ignored.
REQ-041 Back-to-back: req0 held high across 7 random operand pairs -> every result matches d1/d2 and d1%d2, and each result arrives within 20 cycles of load.
